ahb_fir_ctrl: RTL and testbench

AHB_FIR_CTRL -- requirements
Module: ahb_fir_ctrl

---
 rtl/ahb_fir_pkg.sv | 26 ++
 rtl/ahb_fir_regs.sv | 136 +++++++++++++
 rtl/ahb_fir_ctrl.sv | 124 ++++++++++++
 tb/tb_ahb_fir_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_fir_pkg.sv
// Shared definitions for the AHB-Lite FIR sample-rate controller:
// bus geometry, FSM encoding, register map and bit positions.
package ahb_fir_pkg;

  localparam int AWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/ahb_fir_regs.sv
// AHB-Lite address/data phase tracking and the CTRL/DIV/COUNT/STATUS register file.
// start/stop/done-clear are decoded as single-cycle pulses for the controller FSM.
module ahb_fir_regs
  import ahb_fir_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic [DWIDTH-1:0] hrdata,
  input  logic              busy,
  input  logic              done_set,
  input  logic              start_acc,
  output logic              start_wr,
  output logic              stop_wr,
  output logic              done_clr_wr,
  output logic              cont,
  output logic              irq_en,
  output logic [DWIDTH-1:0] div,
  output logic [DWIDTH-1:0] count,
  output logic              done
);

  logic              hsel_q, hsel_d;
  logic [1:0]        addr_q, addr_d;
  logic              hwrite_q, hwrite_d;
  logic              trans_q, trans_d;
  logic              cont_q, cont_d;
  logic              irq_en_q, irq_en_d;
  logic [DWIDTH-1:0] div_q, div_d;
  logic [DWIDTH-1:0] count_q, count_d;
  logic              done_q, done_d;
  logic              wr_en;
  logic              unused_bits;

  assign unused_bits = ^{haddr[AWIDTH-1:2], htrans[0]};

  // A write is applied at the edge ending its data phase, using the phase captured earlier.
  assign wr_en       = hsel_q & trans_q & hwrite_q;
  assign start_wr    = wr_en && (addr_q == ADDR_CTRL)   && hwdata[CTRL_START];
  assign stop_wr     = wr_en && (addr_q == ADDR_CTRL)   && hwdata[CTRL_STOP];
  assign done_clr_wr = wr_en && (addr_q == ADDR_STATUS) && hwdata[STAT_DONE];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hsel_d   = hsel_q;
    addr_d   = addr_q;
    hwrite_d = hwrite_q;
    trans_d  = trans_q;
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    count_d  = count_q;
    done_d   = done_q;

    if (hready) begin
      hsel_d   = hsel;
      addr_d   = haddr[1:0];
      hwrite_d = hwrite;
      trans_d  = htrans[1];
    end

    if (wr_en) begin
      case (addr_q)
        ADDR_CTRL: begin
          cont_d   = hwdata[CTRL_CONT];
          irq_en_d = hwdata[CTRL_IRQ_EN];
        end
        ADDR_DIV:   div_d   = hwdata;
        ADDR_COUNT: count_d = hwdata;
        default:    ;
      endcase
    end

    // Setting done wins over a same-cycle write-1-to-clear or start.
    if (done_set) begin
      done_d = 1'b1;
    end else if (done_clr_wr || start_acc) begin
      done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, with every flop in the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsel_q   <= 1'b0;
      addr_q   <= 2'd0;
      hwrite_q <= 1'b0;
      trans_q  <= 1'b0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      hsel_q   <= hsel_d;
      addr_q   <= addr_d;
      hwrite_q <= hwrite_d;
      trans_q  <= trans_d;
      cont_q   <= cont_d;
      irq_en_q <= irq_en_d;
      div_q    <= div_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    hrdata = '0;
    case (addr_q)
      ADDR_CTRL: begin
        hrdata[CTRL_CONT]   = cont_q;
        hrdata[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_DIV:   hrdata = div_q;
      ADDR_COUNT: hrdata = count_q;
      default: begin
        hrdata[STAT_BUSY] = busy;
        hrdata[STAT_DONE] = done_q;
      end
    endcase
  end

  assign cont   = cont_q;
  assign irq_en = irq_en_q;
  assign div    = div_q;
  assign count  = count_q;
  assign done   = done_q;

endmodule

// File: rtl/ahb_fir_ctrl.sv
// FIR sample-rate controller: AHB-Lite slave plus IDLE/RUN/DONE FSM generating
// a sample_en strobe every DIV+1 cycles, one-shot (COUNT samples) or continuous.
module ahb_fir_ctrl
  import ahb_fir_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DWIDTH-1:0] hrdata,
  output logic              sample_en,
  output logic              busy,
  output logic              irq
);

  fsm_state_e        state_q, state_d;
  logic [DWIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DWIDTH-1:0] smp_cnt_q, smp_cnt_d;
  logic              start_wr, stop_wr, done_clr_wr;
  logic              cont, irq_en, done;
  logic              done_set, start_acc;
  logic [DWIDTH-1:0] div, count;
  logic              unused_hsize;

  assign unused_hsize = ^hsize;
  assign hreadyout    = 1'b1;
  assign hresp        = 1'b0;

  ahb_fir_regs #(.DWIDTH(DWIDTH)) u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsel        (hsel),
    .haddr       (haddr),
    .hwrite      (hwrite),
    .htrans      (htrans),
    .hwdata      (hwdata),
    .hready      (hready),
    .hrdata      (hrdata),
    .busy        (busy),
    .done_set    (done_set),
    .start_acc   (start_acc),
    .start_wr    (start_wr),
    .stop_wr     (stop_wr),
    .done_clr_wr (done_clr_wr),
    .cont        (cont),
    .irq_en      (irq_en),
    .div         (div),
    .count       (count),
    .done        (done)
  );

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    smp_cnt_d = smp_cnt_q;
    sample_en = 1'b0;
    done_set  = 1'b0;
    start_acc = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Stop in the same CTRL write suppresses start.
        if (start_wr && !stop_wr) begin
          start_acc = 1'b1;
          div_cnt_d = div;
          smp_cnt_d = count;
          if (!cont && (count == '0)) begin
            state_d  = ST_DONE;
            done_set = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if ((state_q == ST_DONE) && done_clr_wr) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        sample_en = (div_cnt_q == '0);
        if (stop_wr) begin
          state_d = ST_IDLE;
        end else if (sample_en) begin
          div_cnt_d = div;
          if (!cont) begin
            smp_cnt_d = smp_cnt_q - 1'b1;
            if (smp_cnt_q <= DWIDTH'(1)) begin
              state_d  = ST_DONE;
              done_set = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign irq  = done & irq_en;

endmodule

// File: tb/tb_ahb_fir_ctrl.sv
// Self-checking bench for ahb_fir_ctrl: register vector table plus directed
// multi-cycle sequences for one-shot, continuous, zero-count, DIV change and reset.
module tb_ahb_fir_ctrl;
  import ahb_fir_pkg::*;

  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hsel;
  logic [AWIDTH-1:0] haddr;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [DW-1:0]     hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DW-1:0]     hrdata;
  logic              sample_en;
  logic              busy;
  logic              irq;

  ahb_fir_ctrl #(.DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsel      (hsel),
    .haddr     (haddr),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .sample_en (sample_en),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle stamp of every strobe, sampled mid-cycle.
  int strobe_t[$];
  always @(negedge clk) if (sample_en) strobe_t.push_back(cyc);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_from(input int t0);
    int n = 0;
    foreach (strobe_t[i]) if (strobe_t[i] >= t0) n++;
    return n;
  endfunction

  function automatic int strobe_rel(input int t0, input int n);
    int k = 0;
    foreach (strobe_t[i]) begin
      if (strobe_t[i] >= t0) begin
        if (k == n) return strobe_t[i] - t0;
        k++;
      end
    end
    return -1;
  endfunction

  // Address phase, data phase, then return in the cycle after the write edge.
  task automatic ahb_write(input logic [1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    hsel = 1'b1; haddr = AWIDTH'(a); hwrite = 1'b1; htrans = 2'b10;
    @(negedge clk);
    hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hwdata = d;
    @(negedge clk);
  endtask

  task automatic ahb_read(input logic [1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    hsel = 1'b1; haddr = AWIDTH'(a); hwrite = 1'b0; htrans = 2'b10;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    d = hrdata;
  endtask

  typedef struct {
    logic [1:0]    wa;
    logic [DW-1:0] wd;
    logic [1:0]    ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] rd;
    int t0, t_rel, irq_at;

    vecs[0] = '{ADDR_DIV,    8'hA5, ADDR_DIV,    8'hA5};
    vecs[1] = '{ADDR_COUNT,  8'h5A, ADDR_COUNT,  8'h5A};
    vecs[2] = '{ADDR_CTRL,   8'hFC, ADDR_CTRL,   8'h0C};
    vecs[3] = '{ADDR_CTRL,   8'h04, ADDR_CTRL,   8'h04};
    vecs[4] = '{ADDR_CTRL,   8'h03, ADDR_STATUS, 8'h00};
    vecs[5] = '{ADDR_CTRL,   8'h00, ADDR_CTRL,   8'h00};
    vecs[6] = '{ADDR_STATUS, 8'hFF, ADDR_STATUS, 8'h00};
    vecs[7] = '{ADDR_DIV,    8'h00, ADDR_DIV,    8'h00};

    rst_n = 1'b0; hsel = 1'b0; haddr = '0; hsize = 3'b000; hwrite = 1'b0;
    htrans = 2'b00; hwdata = '0; hready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sample_en", 32'(sample_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_hrdata", 32'(hrdata), 0);
    check("hreadyout", 32'(hreadyout), 1);
    check("hresp", 32'(hresp), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register table; nothing in it may start a run.
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      ahb_write(vecs[i].wa, vecs[i].wd);
      ahb_read(vecs[i].ra, rd);
      check($sformatf("vec%0d_read", i), 32'(rd), 32'(vecs[i].exp));
      check($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end
    check("table_no_strobes", count_from(t0), 0);

    // One-shot DIV=3 COUNT=4: strobes at +3,+7,+11,+15 then DONE.
    ahb_write(ADDR_DIV, 8'd3);
    ahb_write(ADDR_COUNT, 8'd4);
    ahb_write(ADDR_CTRL, 8'h01);
    t0 = cyc;
    check("oneshot_busy_first", 32'(busy), 1);
    repeat (20) @(negedge clk);
    check("oneshot_nstrobe", count_from(t0), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("oneshot_strobe%0d", k), strobe_rel(t0, k), 3 + 4 * k);
    check("oneshot_busy_end", 32'(busy), 0);
    check("oneshot_irq_masked", 32'(irq), 0);
    ahb_read(ADDR_STATUS, rd);
    check("oneshot_status", 32'(rd), 32'h02);

    // Same run from DONE with irq_en: irq rises with done at cycle +16.
    ahb_write(ADDR_CTRL, 8'h09);
    irq_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (irq) begin
        irq_at = i;
        break;
      end
      @(negedge clk);
    end
    check("irq_rise_cycle", irq_at, 16);
    check("irq_busy", 32'(busy), 0);
    ahb_write(ADDR_STATUS, 8'h02);
    check("irq_cleared", 32'(irq), 0);
    ahb_read(ADDR_STATUS, rd);
    check("status_after_clr", 32'(rd), 32'h00);

    // Continuous DIV=0, stop takes effect after 10 strobe cycles.
    ahb_write(ADDR_DIV, 8'd0);
    ahb_write(ADDR_CTRL, 8'h05);
    t0 = cyc;
    repeat (7) @(negedge clk);
    ahb_write(ADDR_CTRL, 8'h02);
    repeat (10) @(negedge clk);
    check("cont_nstrobe", count_from(t0), 10);
    check("cont_first", strobe_rel(t0, 0), 0);
    check("cont_last", strobe_rel(t0, 9), 9);
    check("cont_busy", 32'(busy), 0);
    ahb_read(ADDR_STATUS, rd);
    check("cont_status", 32'(rd), 32'h00);

    // COUNT=0 one-shot: straight to DONE, no strobe.
    t0 = cyc;
    ahb_write(ADDR_COUNT, 8'd0);
    ahb_write(ADDR_CTRL, 8'h01);
    check("zero_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("zero_nstrobe", count_from(t0), 0);
    ahb_read(ADDR_STATUS, rd);
    check("zero_status", 32'(rd), 32'h02);
    ahb_write(ADDR_STATUS, 8'h02);

    // DIV 3 -> 1 mid-run: strobes +3,+7 then period 2 from the reload at +7.
    ahb_write(ADDR_DIV, 8'd3);
    ahb_write(ADDR_COUNT, 8'd10);
    ahb_write(ADDR_CTRL, 8'h01);
    t0 = cyc;
    repeat (2) @(negedge clk);
    ahb_write(ADDR_DIV, 8'd1);
    repeat (10) @(negedge clk);
    check("divchg_s0", strobe_rel(t0, 0), 3);
    check("divchg_s1", strobe_rel(t0, 1), 7);
    check("divchg_s2", strobe_rel(t0, 2), 9);
    check("divchg_s3", strobe_rel(t0, 3), 11);
    ahb_write(ADDR_CTRL, 8'h02);
    check("divchg_stopped", 32'(busy), 0);

    // Reset mid-run while strobing.
    ahb_write(ADDR_DIV, 8'd0);
    ahb_write(ADDR_CTRL, 8'h05);
    repeat (3) @(negedge clk);
    check("pre_rst_strobe", 32'(sample_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sample_en", 32'(sample_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_irq", 32'(irq), 0);
    check("midrst_hrdata", 32'(hrdata), 0);
    @(negedge clk);
    t_rel = cyc;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_nstrobe", count_from(t_rel), 0);
    check("post_rst_busy", 32'(busy), 0);
    ahb_read(ADDR_DIV, rd);
    check("post_rst_div", 32'(rd), 0);
    ahb_read(ADDR_COUNT, rd);
    check("post_rst_count", 32'(rd), 0);
    ahb_read(ADDR_CTRL, rd);
    check("post_rst_ctrl", 32'(rd), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
